// File: rtl/reg_file_rename.sv
// reg_file_rename
//
// Architectural register file with per-register rename tags. It sits directly
// downstream of the reorder buffer commit port. Decode/issue renames rd to the
// ROB slot that will produce it. Commit writes the value back and clears the
// tag only when that slot is still the newest producer. Two source queries are
// answered combinationally with either a committed value or the slot to wait on.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset (priority over all)
//   rdy               global ready; low holds all state
//   rollback          misprediction flush: clears every busy bit, drops issue
//   issue, issue_rd, issue_rob_pos
//                     rename issue_rd to ROB slot issue_rob_pos
//   commit_write, commit_rd, commit_val, commit_rob_pos
//                     commit a register write from the ROB
//   rs1_pos / rs2_pos source indices
//   rsN_val, rsN_busy, rsN_rob_pos
//                     committed value, pending flag and producing ROB slot
//
// Optional build macro:
//   REGFILE_COMMIT_BYPASS_EN  forward a same-cycle commit that retires the
//                             queried register's current tag to the outputs.
module reg_file_rename #(
  parameter int DATA_W    = 32,
  parameter int REG_POS_W = 5,
  parameter int NUM_REGS  = 32,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue,
  input  logic [REG_POS_W-1:0] issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic                 commit_write,
  input  logic [REG_POS_W-1:0] commit_rd,
  input  logic [DATA_W-1:0]    commit_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  input  logic [REG_POS_W-1:0] rs1_pos,
  output logic [DATA_W-1:0]    rs1_val,
  output logic                 rs1_busy,
  output logic [ROB_POS_W-1:0] rs1_rob_pos,
  input  logic [REG_POS_W-1:0] rs2_pos,
  output logic [DATA_W-1:0]    rs2_val,
  output logic                 rs2_busy,
  output logic [ROB_POS_W-1:0] rs2_rob_pos
);

  logic [DATA_W-1:0]    val_q [NUM_REGS];
  logic [ROB_POS_W-1:0] tag_q [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q;

  logic                 issue_ok;
  logic                 commit_ok;
  logic [NUM_REGS-1:0]  issue_sel;
  logic [NUM_REGS-1:0]  commit_sel;

  assign issue_ok  = issue && !rollback && (issue_rd != '0);
  assign commit_ok = commit_write && (commit_rd != '0);

  // One-hot write selects; entry 0 is never selected so x0 stays zero.
  always_comb begin
    issue_sel  = '0;
    commit_sel = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      issue_sel[i]  = issue_ok  && (issue_rd  == REG_POS_W'(i));
      commit_sel[i] = commit_ok && (commit_rd == REG_POS_W'(i));
    end
  end

  // Busy priority: rollback clears all, then a new rename wins over a commit
  // to the same register, then a commit clears busy only if it retires the
  // tag currently recorded (an older producer leaves the newer rename pending).
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (rdy) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (commit_sel[i]) begin
          val_q[i] <= commit_val;
        end
        if (rollback) begin
          busy_q[i] <= 1'b0;
        end else if (issue_sel[i]) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= issue_rob_pos;
        end else if (commit_sel[i] && (tag_q[i] == commit_rob_pos)) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // Query ports: plain read of registered state; index 0 (and any index
  // beyond NUM_REGS) reads as all zero.
  always_comb begin
    rs1_val     = '0;
    rs1_busy    = 1'b0;
    rs1_rob_pos = '0;
    rs2_val     = '0;
    rs2_busy    = 1'b0;
    rs2_rob_pos = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (rs1_pos == REG_POS_W'(i)) begin
        rs1_val     = val_q[i];
        rs1_busy    = busy_q[i];
        rs1_rob_pos = tag_q[i];
      end
      if (rs2_pos == REG_POS_W'(i)) begin
        rs2_val     = val_q[i];
        rs2_busy    = busy_q[i];
        rs2_rob_pos = tag_q[i];
      end
    end
`ifdef REGFILE_COMMIT_BYPASS_EN
    // Forward only when this commit is the one the register is waiting on;
    // rob_pos is left as the registered tag.
    if (commit_write && rdy && (rs1_pos != '0) && (commit_rd == rs1_pos) &&
        rs1_busy && (rs1_rob_pos == commit_rob_pos)) begin
      rs1_busy = 1'b0;
      rs1_val  = commit_val;
    end
    if (commit_write && rdy && (rs2_pos != '0) && (commit_rd == rs2_pos) &&
        rs2_busy && (rs2_rob_pos == commit_rob_pos)) begin
      rs2_busy = 1'b0;
      rs2_val  = commit_val;
    end
`endif
  end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags, directly downstream of the reorder buffer's commit port.
- The decode/issue stage renames each rd by recording the ROB slot that will produce it. The ROB's registered commit outputs write back the value and clear the tag once it is no longer superseded.
- The decoder queries two source registers per cycle. For each it gets either a committed value or the ROB position to wait on.

Parameters:
- DATA_W, 32, register value width
- REG_POS_W, 5, register index width
- NUM_REGS, 32, number of architectural registers (x0 hardwired zero)
- ROB_POS_W, 4, ROB position width (ROB size 2**ROB_POS_W)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low = hold all state
- rollback  in  1  misprediction flush from ROB
- issue  in  1  instruction issued this cycle
- issue_rd  in  REG_POS_W  destination register of issued instruction
- issue_rob_pos  in  ROB_POS_W  ROB slot allocated to issued instruction
- commit_write  in  1  ROB commits a register write
- commit_rd  in  REG_POS_W  committed destination
- commit_val  in  DATA_W  committed value
- commit_rob_pos  in  ROB_POS_W  ROB slot being committed
- rs1_pos  in  REG_POS_W  source 1 index
- rs1_val  out  DATA_W  source 1 committed value
- rs1_busy  out  1  source 1 pending in ROB
- rs1_rob_pos  out  ROB_POS_W  ROB slot producing source 1
- rs2_pos, rs2_val, rs2_busy, rs2_rob_pos  same as rs1 for source 2

Behaviour:
- State per register: val[DATA_W], busy[1], tag[ROB_POS_W].
- rst: all val=0, busy=0, tag=0. rst has priority over every other input.
- rdy=0 (no rst): no state change. Query outputs stay combinational.
- Query outputs are combinational from current state and do not reflect this cycle's issue.
  - rsN_val = val[pos], rsN_busy = busy[pos], rsN_rob_pos = tag[pos].
  - pos=0 always gives val=0, busy=0, rob_pos=0.
  - After reset, all outputs read 0.
- Issue, on the posedge when issue && rdy && !rollback && issue_rd!=0: busy[rd]<=1, tag[rd]<=issue_rob_pos. Re-renaming an already busy register overwrites the tag.
- Commit, on the posedge when commit_write && rdy && commit_rd!=0:
  - val[commit_rd]<=commit_val, always, regardless of tag.
  - busy[commit_rd]<=0 only if tag[commit_rd]==commit_rob_pos, and not (issue accepted with issue_rd==commit_rd) in the same cycle.
- Simultaneous issue and commit on the same rd: value written, busy stays 1, tag takes issue_rob_pos (issue wins).
- Rollback:
  - busy of every register <=0 in that cycle. Values and tags are retained.
  - Issue is ignored.
  - Commit in the same cycle is still applied. Its busy clear is irrelevant because all busy bits clear.
- Writes to x0 (issue or commit) have no effect; x0 is never busy.
- Single cycle latency: a write at edge N is visible on query outputs after edge N.
- ROB position wrap-around needs no special handling; tags are compared for equality only.

Optional Feature:
- Macro: REGFILE_COMMIT_BYPASS_EN.
- Defined: a same-cycle commit is forwarded to the query outputs. A query qualifies when commit_write && rdy && commit_rd==rsN_pos!=0 && busy[pos] && tag[pos]==commit_rob_pos. For a qualifying query, rsN_busy=0 and rsN_val=commit_val, so the decoder sees the value one cycle earlier.
- Undefined: queries reflect registered state only. The same-cycle commit becomes visible next cycle.

Test Plan:
- Reset, then query rs1=5, rs2=0 -> both val=0, busy=0, rob_pos=0.
- Issue rd=3, rob_pos=2; next cycle query rs1=3 -> busy=1, rob_pos=2. Then commit rd=3, rob_pos=2, val=0xDEADBEEF -> next cycle busy=0, val=0xDEADBEEF.
- Issue rd=7 at rob 1, then rd=7 at rob 4. Commit rd=7, rob 1, val=0x11 -> val=0x11, busy=1, rob_pos=4. Commit rob 4, val=0x22 -> busy=0, val=0x22.
- Same cycle: commit rd=9 rob 5 val=0x55 and issue rd=9 rob 6 -> val=0x55, busy=1, rob_pos=6.
- Regs 1,2,4 busy. Assert rollback together with issue rd=8 and commit rd=1, val=0xAB -> all busy=0, reg1 val=0xAB, reg8 not busy. rdy=0 with issue/commit -> no state change. Issue/commit to x0 -> x0 reads 0, not busy.
- With REGFILE_COMMIT_BYPASS_EN: reg 10 busy at rob 3. Commit rd=10 rob 3 val=0x77 while querying rs2=10 -> same cycle rs2_busy=0, rs2_val=0x77. Without the macro -> rs2_busy=1 that cycle, and val=0x77 next cycle.
